// File: rtl/riscv_pkg.sv
// Shared definitions for the memory / write-back stage.
//   XLEN           : datapath width
//   F3_*           : load/store funct3 encodings
//   state_e        : mem_wb_unit FSM states
//   mem_op_bad()   : flags misaligned addresses or reserved funct3 for a memory op
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Unsigned variants exist only for loads; a store carrying them is treated
  // as a reserved encoding.
  function automatic logic mem_op_bad(input logic       is_load,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = !is_load;
      F3_HU:   bad = !is_load || off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatting: picks the byte/half lane addressed by off and
// sign- or zero-extends it according to funct3.
//   rdata  : raw 32-bit word from memory
//   off    : byte offset within the word (address[1:0])
//   funct3 : load width / signedness
//   data   : register-file ready value
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Halfword loads are already known aligned, so shifting by off*8 lands
  // the addressed lane at bit 0 for both byte and half cases.
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory access + write-back stage. Accepts one op from EX, issues at most
// one data-memory request, formats load data and drives the register-file
// write port for one cycle.
//   clk, rst                 : clock, async active-high reset
//   ex_*                     : op from EX, handshake ex_valid/ex_ready
//   mem_req/we/addr/wstrb/wdata, mem_ack/rdata : data-memory port
//   write_reg, rd, write_back_data             : register-file write port
//   misalign_err, timeout_err                  : one-cycle error pulses
// Build option: define MEM_WB_TIMEOUT_EN to abort a request after
// TIMEOUT_CYC cycles without mem_ack; otherwise REQ waits forever.
module mem_wb_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_wb_en,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            write_reg,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_back_data,
  output logic            misalign_err,
  output logic            timeout_err
);

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            write_reg_q, write_reg_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;
  // Pending-load context kept across the REQ wait.
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            ld_wr_q, ld_wr_d;

  logic [XLEN-1:0] ld_data;
  logic            accept;

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYC[0];
  assign timeout_err        = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (ld_off_q),
    .funct3 (ld_f3_q),
    .data   (ld_data)
  );

  assign ex_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
  assign accept   = ex_valid && ex_ready;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    write_reg_d = 1'b0;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    ld_wr_d     = ld_wr_q;
`ifdef MEM_WB_TIMEOUT_EN
    to_cnt_d    = '0;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_REQ: begin
`ifdef MEM_WB_TIMEOUT_EN
        to_cnt_d = to_cnt_q + CW'(1);
`endif
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = ST_IDLE;
          end else begin
            wb_data_d   = ld_data;
            write_reg_d = ld_wr_q;
            state_d     = ST_WB;
          end
        end
`ifdef MEM_WB_TIMEOUT_EN
        else if (to_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
`endif
      end

      default: begin
        // IDLE and WB both accept; WB's write is already on the outputs.
        state_d = ST_IDLE;
        if (accept) begin
          if (ex_is_load || ex_is_store) begin
            if (mem_op_bad(ex_is_load, ex_funct3, ex_result[1:0])) begin
              misalign_d = 1'b1;
            end else begin
              state_d     = ST_REQ;
              mem_req_d   = 1'b1;
              mem_we_d    = !ex_is_load;
              mem_addr_d  = {ex_result[XLEN-1:2], 2'b00};
              rd_d        = ex_rd;
              ld_f3_d     = ex_funct3;
              ld_off_d    = ex_result[1:0];
              ld_wr_d     = ex_is_load && ex_wb_en && (ex_rd != 5'd0);
              mem_wstrb_d = 4'b0000;
              mem_wdata_d = '0;
              if (!ex_is_load) begin
                case (ex_funct3)
                  F3_B: begin
                    mem_wstrb_d = 4'b0001 << ex_result[1:0];
                    mem_wdata_d = {4{ex_store_data[7:0]}};
                  end
                  F3_H: begin
                    mem_wstrb_d = ex_result[1] ? 4'b1100 : 4'b0011;
                    mem_wdata_d = {2{ex_store_data[15:0]}};
                  end
                  default: begin
                    mem_wstrb_d = 4'b1111;
                    mem_wdata_d = ex_store_data;
                  end
                endcase
              end
            end
          end else if (ex_wb_en) begin
            state_d     = ST_WB;
            write_reg_d = (ex_rd != 5'd0);
            rd_d        = ex_rd;
            wb_data_d   = ex_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      write_reg_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      ld_wr_q     <= 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      write_reg_q <= write_reg_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      ld_wr_q     <= ld_wr_d;
`ifdef MEM_WB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wstrb       = mem_wstrb_q;
  assign mem_wdata       = mem_wdata_q;
  assign write_reg       = write_reg_q;
  assign rd              = rd_q;
  assign write_back_data = wb_data_q;
  assign misalign_err    = misalign_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
module tb_mem_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_wb_en, ex_is_load, ex_is_store;
  logic [4:0]  ex_rd, rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result, ex_store_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, write_back_data;
  logic [3:0]  mem_wstrb;
  logic        write_reg, misalign_err, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  string cur = "";

  always #5 clk = ~clk;

  mem_wb_unit #(.TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .write_reg(write_reg), .rd(rd), .write_back_data(write_back_data),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] wbd;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", cur, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic wb, input logic [4:0] r, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd);
    ex_valid = 1'b1; ex_wb_en = wb; ex_rd = r; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_result = res; ex_store_data = sd;
  endtask

  task automatic do_vec(input int i);
    vec_t v;
    v = tv[i];
    cur = $sformatf("vec%0d", i);
    @(negedge clk);
    drive(v.wb, v.rd, v.ld, v.st, v.f3, v.res, v.sd);
    mem_rdata = v.rdata;
    chk("ex_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    if (v.mis) begin
      chk("misalign_err", {31'd0, misalign_err}, 32'd1);
      chk("mem_req", {31'd0, mem_req}, 32'd0);
      chk("write_reg", {31'd0, write_reg}, 32'd0);
      tick();
      chk("misalign_clr", {31'd0, misalign_err}, 32'd0);
    end else if (v.ld || v.st) begin
      chk("mem_req", {31'd0, mem_req}, 32'd1);
      chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.strb});
      if (v.st) chk("mem_wdata", mem_wdata, v.wdata);
      chk("ex_ready_req", {31'd0, ex_ready}, 32'd0);
      repeat (2) begin
        tick();
        chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
        chk("mem_addr_hold", mem_addr, v.addr);
      end
      @(negedge clk); mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
      chk("write_reg", {31'd0, write_reg}, {31'd0, v.wreg});
      if (v.wreg) begin
        chk("wb_data", write_back_data, v.wbd);
        chk("rd", {27'd0, rd}, {27'd0, v.rd});
      end
      tick();
      chk("write_reg_clr", {31'd0, write_reg}, 32'd0);
    end else begin
      chk("write_reg", {31'd0, write_reg}, {31'd0, v.wreg});
      if (v.wreg) begin
        chk("wb_data", write_back_data, v.wbd);
        chk("rd", {27'd0, rd}, {27'd0, v.rd});
      end
      tick();
      chk("write_reg_clr", {31'd0, write_reg}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    logic seen;
    //          wb    rd   ld    st    f3      res           sd            rdata         mis   addr          strb     wdata         wreg  wbd
    tv[0]  = '{1'b1, 5'd5, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_1234};
    tv[1]  = '{1'b1, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0000_5678, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    tv[2]  = '{1'b0, 5'd7, 1'b0, 1'b0, 3'b000, 32'h0000_9999, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    tv[3]  = '{1'b1, 5'd3, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,       1'b1, 32'hFFFF_FF80};
    tv[4]  = '{1'b1, 5'd3, 1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,       1'b1, 32'h0000_00FF};
    tv[5]  = '{1'b1, 5'd4, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,       1'b1, 32'hFFFF_80FF};
    tv[6]  = '{1'b1, 5'd4, 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,       1'b1, 32'h0000_FF00};
    tv[7]  = '{1'b1, 5'd9, 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,       1'b1, 32'hDEAD_BEEF};
    tv[8]  = '{1'b0, 5'd0, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 5'd0, 1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_5678, 32'h0,       1'b0, 32'h0000_0300, 4'b0010, 32'h7878_7878, 1'b0, 32'h0};
    tv[10] = '{1'b0, 5'd0, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,       1'b0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    tv[11] = '{1'b1, 5'd6, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    tv[12] = '{1'b0, 5'd0, 1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1111,     32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    tv[13] = '{1'b1, 5'd6, 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    tv[14] = '{1'b1, 5'd0, 1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_0055, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,       1'b0, 32'h0};

    ex_valid = 0; ex_wb_en = 0; ex_rd = 0; ex_is_load = 0; ex_is_store = 0;
    ex_funct3 = 0; ex_result = 0; ex_store_data = 0; mem_ack = 0; mem_rdata = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur = "reset";
    chk("mem_req", {31'd0, mem_req}, 32'd0);
    chk("mem_we", {31'd0, mem_we}, 32'd0);
    chk("write_reg", {31'd0, write_reg}, 32'd0);
    chk("misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rd", {27'd0, rd}, 32'd0);
    chk("mem_addr", mem_addr, 32'd0);
    chk("mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("mem_wdata", mem_wdata, 32'd0);
    chk("wb_data", write_back_data, 32'd0);
    chk("ex_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) do_vec(i);

    // Back-to-back ALU ops, one per cycle through WB.
    cur = "b2b";
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 1'b0, 3'b000, 32'hA1, 32'h0);
    tick();
    chk("wr1", {31'd0, write_reg}, 32'd1);
    chk("d1", write_back_data, 32'hA1);
    chk("ready_wb", {31'd0, ex_ready}, 32'd1);
    drive(1'b1, 5'd2, 1'b0, 1'b0, 3'b000, 32'hB2, 32'h0);
    tick();
    chk("wr2", {31'd0, write_reg}, 32'd1);
    chk("d2", write_back_data, 32'hB2);
    chk("rd2", {27'd0, rd}, 32'd2);
    drive(1'b1, 5'd3, 1'b0, 1'b0, 3'b000, 32'hC3, 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("wr3", {31'd0, write_reg}, 32'd1);
    chk("d3", write_back_data, 32'hC3);
    tick();
    chk("wr_clr", {31'd0, write_reg}, 32'd0);

    // Misaligned word, then an op accepted the very next cycle.
    cur = "mis_then_op";
    @(negedge clk);
    drive(1'b1, 5'd8, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    tick();
    chk("mis", {31'd0, misalign_err}, 32'd1);
    chk("ready", {31'd0, ex_ready}, 32'd1);
    drive(1'b1, 5'd8, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("mis_clr", {31'd0, misalign_err}, 32'd0);
    chk("wr", {31'd0, write_reg}, 32'd1);
    chk("d", write_back_data, 32'h77);

    // Load-use latency: accept N, ack N+1, writeback N+2.
    cur = "latency";
    @(negedge clk);
    drive(1'b1, 5'd10, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    mem_rdata = 32'h1357_9BDF;
    tick();
    ex_valid = 1'b0;
    chk("req", {31'd0, mem_req}, 32'd1);
    chk("wr_n1", {31'd0, write_reg}, 32'd0);
    @(negedge clk); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_n2", {31'd0, write_reg}, 32'd1);
    chk("d", write_back_data, 32'h1357_9BDF);
    chk("rd", {27'd0, rd}, 32'd10);

    // Stray ack outside REQ is ignored.
    cur = "stray_ack";
    tick();
    @(negedge clk); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr", {31'd0, write_reg}, 32'd0);
    chk("req", {31'd0, mem_req}, 32'd0);
    chk("ready", {31'd0, ex_ready}, 32'd1);

    // Reset mid-REQ drops mem_req without a clock; later ack ignored.
    cur = "rst_mid_req";
    @(negedge clk);
    drive(1'b1, 5'd11, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    mem_rdata = 32'h2468_ACE0;
    tick();
    ex_valid = 1'b0;
    chk("req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("req_async", {31'd0, mem_req}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr", {31'd0, write_reg}, 32'd0);
    chk("req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("wr2", {31'd0, write_reg}, 32'd0);

    // Timeout behaviour.
    cur = "timeout";
    @(negedge clk);
    drive(1'b1, 5'd12, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    mem_rdata = 32'h0BAD_F00D;
    tick();
    ex_valid = 1'b0;
    chk("req", {31'd0, mem_req}, 32'd1);
    cyc = 0;
    seen = 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
    while (!seen && cyc < 400) begin
      tick();
      cyc++;
      if (timeout_err) seen = 1'b1;
    end
    chk("seen", {31'd0, seen}, 32'd1);
    chk("cycles", cyc, 32'd255);
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    chk("wr", {31'd0, write_reg}, 32'd0);
    tick();
    chk("pulse_clr", {31'd0, timeout_err}, 32'd0);
`else
    while (cyc < 300) begin
      tick();
      cyc++;
      if (timeout_err || !mem_req) seen = 1'b1;
    end
    chk("no_abort", {31'd0, seen}, 32'd0);
    @(negedge clk); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr", {31'd0, write_reg}, 32'd1);
    chk("d", write_back_data, 32'h0BAD_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of mem_ack wait cycles before abort (used only when timeout is compiled in).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid in 1 EX op offered; ex_ready out 1 op accepted when both high.
REQ-005 ex_wb_en in 1, ex_rd in 5, ex_is_load in 1, ex_is_store in 1, ex_funct3 in 3, all qualified by ex_valid.
REQ-006 ex_result in 32 ALU result or effective address; ex_store_data in 32 store source.
REQ-007 mem_req out 1, mem_we out 1, mem_addr out 32 word-aligned, mem_wstrb out 4, mem_wdata out 32.
REQ-008 mem_ack in 1 one-cycle completion; mem_rdata in 32 valid with mem_ack.
REQ-009 write_reg out 1, rd out 5, write_back_data out 32: register-file write port.
REQ-010 misalign_err out 1, timeout_err out 1: one-cycle error pulses.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WB; ex_ready SHALL be high only in IDLE and WB.
REQ-012 Accepted non-memory op with ex_wb_en: next state WB; write_reg=1 for exactly one cycle, write_back_data=ex_result.
REQ-013 Accepted load/store: next state REQ; mem_req and all mem_* outputs SHALL hold stable until the cycle mem_ack=1.
REQ-014 Load ack: capture formatted rdata, go to WB, write back next cycle; store ack: go to IDLE, no writeback.
REQ-015 Load formatting: funct3 000 LB, 001 LH sign-extended; 100 LBU, 101 LHU zero-extended; 010 LW; lane selected by ex_result[1:0].
REQ-016 Store: 000 SB wstrb one-hot by addr[1:0], data replicated to all bytes; 001 SH wstrb 0011/1100; 010 SW wstrb 1111.
REQ-017 Misaligned (half at addr[0]=1, word at addr[1:0]!=0) or reserved funct3 on load/store: no mem_req, misalign_err pulse next cycle, no writeback, state IDLE.
REQ-018 write_reg SHALL be 0 whenever rd==0 or ex_wb_en==0, regardless of op.
REQ-019 In WB with ex_valid=1, the new op SHALL be accepted the same cycle (back-to-back, one op/cycle for ALU ops).
REQ-020 mem_ack while not in REQ SHALL be ignored.
REQ-021 Load-use latency: accept at cycle N, earliest writeback N+2 (ack at N+1).

Reset
REQ-022 On rst: state IDLE; mem_req, mem_we, write_reg, misalign_err, timeout_err=0; rd, mem_addr, mem_wstrb, mem_wdata, write_back_data=0.
REQ-023 Reset during REQ SHALL drop mem_req immediately (asynchronously); a later stale mem_ack SHALL be ignored.

Configuration
REQ-024 Macro MEM_WB_TIMEOUT_EN defined: counter starts at REQ entry; after TIMEOUT_CYC cycles without ack, mem_req drops, timeout_err pulses one cycle, no writeback, state IDLE.
REQ-025 Macro undefined: no counter, REQ waits indefinitely, timeout_err tied 0.

Structure
REQ-026 Shared package riscv_pkg SHALL hold XLEN, load/store funct3 constants, and the FSM state enum.
REQ-027 Sub-module load_align (combinational lane select plus sign/zero extension) SHALL be instantiated once.

Verification
REQ-028 ALU op rd=5, result 0x1234 -> write_reg=1, rd=5, data 0x1234 next cycle; rd=0 -> write_reg stays 0.
REQ-029 LB addr 0x103, rdata 0x80FF_FF00, ack after 3 cycles -> mem_addr 0x100, writeback 0xFFFF_FF80 cycle after ack.
REQ-030 SH addr 0x202, data 0xABCD -> wstrb 1100, wdata 0xABCD_ABCD, no writeback.
REQ-031 LW addr 0x101 -> no mem_req, misalign_err pulse, next op accepted following cycle.
REQ-032 rst asserted mid-REQ, then mem_ack -> mem_req 0 immediately, no writeback; with MEM_WB_TIMEOUT_EN, no ack for 255 cycles -> timeout_err pulse.
